// File: rtl/qspi_fetch_buffer.sv
// rtl/qspi_fetch_buffer.sv - sequential instruction prefetch buffer between the QSPI ROM controller and the CU
// Holds up to DEPTH address-tagged words and redirects the fetch stream on jumps or PC mismatch.
module qspi_fetch_buffer #(
   parameter int          DEPTH      = 4,
   parameter int          ADDR_STEP  = 4,
   parameter logic [22:0] RESET_ADDR = 23'h000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic [22:0] cpu_pc,
   input  logic        cpu_take,
   input  logic        cpu_flush,
   output logic        cpu_valid,
   output logic [31:0] cpu_data,
   output logic        qspi_start,
   output logic [22:0] qspi_addr,
   input  logic [31:0] qspi_data,
   input  logic        qspi_busy,
   output logic [3:0]  occupancy
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [3:0]  OCC_MAX  = 4'(DEPTH);
   localparam logic [22:0] STEP     = 23'(ADDR_STEP);

   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

   state_t        state, state_nxt;
   logic [22:0]   tag_mem  [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [3:0]    occ;
   logic [22:0]   fetch_addr, txn_addr;
   logic          discard;

   logic          not_empty, outstanding, done, redirect, push, pop, start;
   logic [22:0]   head_tag, expect_addr;

   assign not_empty   = (occ != 4'd0);
   assign outstanding = (state != IDLE);
   assign done        = (state == WAIT_DONE) && !qspi_busy;
   assign head_tag    = tag_mem[rd_ptr];

   // Address the CU is expected to ask for next if no jump has happened.
   assign expect_addr = not_empty                 ? head_tag :
                        (outstanding && !discard) ? txn_addr : fetch_addr;

   assign redirect  = !rst && (cpu_flush || (cpu_req && (cpu_pc != expect_addr)));
   assign cpu_valid = cpu_req && not_empty && (head_tag == cpu_pc);
   assign cpu_data  = not_empty ? data_mem[rd_ptr] : 32'h0;
   assign pop       = cpu_take && cpu_valid && !redirect;
   assign push      = done && !discard && !redirect;

   assign qspi_start = start;
   assign qspi_addr  = (state == IDLE) ? fetch_addr : txn_addr;
   assign occupancy  = occ;

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         IDLE: begin
            // A redirect edge moves fetch_addr, so issue waits one cycle for it.
            if (!rst && (occ < OCC_MAX) && !qspi_busy && !redirect) begin
               start     = 1'b1;
               state_nxt = WAIT_BUSY;
            end
         end
         WAIT_BUSY: if (qspi_busy) state_nxt = WAIT_DONE;
         WAIT_DONE: if (!qspi_busy) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         occ        <= 4'd0;
         fetch_addr <= RESET_ADDR;
         txn_addr   <= RESET_ADDR;
         discard    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start) txn_addr <= fetch_addr;
         if (redirect) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occ        <= 4'd0;
            fetch_addr <= cpu_pc;
            // A transaction ending on this very edge has nothing left to discard.
            discard    <= outstanding && !done;
         end else begin
            if (push) begin
               wr_ptr     <= wr_ptr + AW'(1);
               fetch_addr <= txn_addr + STEP;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
               2'b10:   occ <= occ + 4'd1;
               2'b01:   occ <= occ - 4'd1;
               default: occ <= occ;
            endcase
            if (done) discard <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wr_ptr]  <= txn_addr;
         data_mem[wr_ptr] <= qspi_data;
      end
   end

endmodule

// File: tb/tb_qspi_fetch_buffer.sv
// tb/tb_qspi_fetch_buffer.sv - directed self-checking bench for qspi_fetch_buffer
// QSPI responder holds busy for BUSY_LEN cycles and returns addr ^ 0xA5A5A5A5.
module tb_qspi_fetch_buffer;

   localparam int BUSY_LEN = 8;

   logic        clk, rst;
   logic        cpu_req, cpu_take, cpu_flush, cpu_valid;
   logic [22:0] cpu_pc, qspi_addr;
   logic [31:0] cpu_data, qspi_data;
   logic        qspi_start, qspi_busy;
   logic [3:0]  occupancy;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          bad_start = 0;
   int          occ_over  = 0;
   int          q_cnt     = 0;
   int          seq_err;
   logic        q_go;
   logic [22:0] q_addr;
   logic [22:0] start_log [$];

   qspi_fetch_buffer #(.DEPTH(4), .ADDR_STEP(4), .RESET_ADDR(23'h0)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_pc     (cpu_pc),
      .cpu_take   (cpu_take),
      .cpu_flush  (cpu_flush),
      .cpu_valid  (cpu_valid),
      .cpu_data   (cpu_data),
      .qspi_start (qspi_start),
      .qspi_addr  (qspi_addr),
      .qspi_data  (qspi_data),
      .qspi_busy  (qspi_busy),
      .occupancy  (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] exp_data(input logic [22:0] a);
      return {9'd0, a} ^ 32'hA5A5A5A5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // QSPI responder: samples start late in the cycle, updates busy/data just after the edge.
   initial begin
      qspi_busy = 1'b0;
      qspi_data = 32'h0;
      q_addr    = 23'h0;
      forever begin
         @(negedge clk);
         #4;
         q_go = qspi_start;
         if (qspi_start) begin
            start_log.push_back(qspi_addr);
            q_addr = qspi_addr;
            if (qspi_busy) bad_start++;
         end
         if (occupancy > 4'd4) occ_over++;
         @(posedge clk);
         #1;
         if (q_cnt != 0) begin
            q_cnt--;
            if (q_cnt == 0) begin
               qspi_busy = 1'b0;
               qspi_data = exp_data(q_addr);
            end
         end else if (q_go) begin
            qspi_busy = 1'b1;
            q_cnt     = BUSY_LEN;
         end
      end
   end

   initial begin
      rst = 1'b1; cpu_req = 1'b0; cpu_pc = 23'h0; cpu_take = 1'b0; cpu_flush = 1'b0;
      tick(); tick();
      cpu_req = 1'b1; cpu_pc = 23'h0;
      #1;
      chk("rst_occ",   occupancy,  4'd0);
      chk("rst_valid", cpu_valid,  1'b0);
      chk("rst_data",  cpu_data,   32'h0);
      chk("rst_start", qspi_start, 1'b0);
      chk("rst_addr",  qspi_addr,  23'h0);

      // Cold start: fill to DEPTH, then no further issue.
      cpu_req = 1'b0; rst = 1'b0;
      for (int i = 0; i < 300 && occupancy != 4'd4; i++) tick();
      chk("cold_occ", occupancy, 4'd4);
      repeat (20) tick();
      chk("cold_nstart", start_log.size(), 4);
      for (int i = 0; i < start_log.size() && i < 4; i++)
         chk("cold_addr", start_log[i], 23'(i * 4));
      cpu_req = 1'b1; cpu_pc = 23'h0;
      #1;
      chk("cold_valid", cpu_valid, 1'b1);
      chk("cold_data",  cpu_data,  32'hA5A5A5A5);

      // Pop 0 and 4, then push and pop on the same edge at occupancy 2.
      cpu_take = 1'b1;
      tick();
      cpu_pc = 23'h4;
      tick();
      cpu_req = 1'b0; cpu_take = 1'b0;
      for (int i = 0; i < 50 && !qspi_busy; i++) tick();
      for (int i = 0; i < 50 && qspi_busy; i++) tick();
      cpu_req = 1'b1; cpu_pc = 23'h8; cpu_take = 1'b1;
      #1;
      chk("sim_occ_pre", occupancy, 4'd2);
      chk("sim_valid",   cpu_valid, 1'b1);
      tick();
      cpu_pc = 23'hC; cpu_take = 1'b0;
      #1;
      chk("sim_occ_post", occupancy, 4'd2);
      chk("sim_head",     cpu_data,  exp_data(23'hC));

      // Streaming through 0x3C.
      for (int p = 'hC; p <= 'h3C; p += 4) begin
         cpu_pc = 23'(p); cpu_take = 1'b0;
         #1;
         for (int i = 0; i < 60 && !cpu_valid; i++) tick();
         chk("stream_data", cpu_data, exp_data(23'(p)));
         cpu_take = 1'b1;
         tick();
      end
      cpu_req = 1'b0; cpu_take = 1'b0;
      seq_err = 0;
      foreach (start_log[i]) if (start_log[i] !== 23'(i * 4)) seq_err++;
      chk("stream_seq", seq_err, 0);

      // Jump while a fetch is in WAIT_DONE.
      for (int i = 0; i < 300 && occupancy != 4'd4; i++) tick();
      cpu_req = 1'b1; cpu_pc = 23'h40; cpu_take = 1'b1;
      tick();
      cpu_req = 1'b0; cpu_take = 1'b0;
      for (int i = 0; i < 50 && !qspi_busy; i++) tick();
      tick(); tick();
      start_log.delete();
      cpu_flush = 1'b1; cpu_req = 1'b1; cpu_pc = 23'h100;
      tick();
      cpu_flush = 1'b0;
      #1;
      chk("jmp_occ",   occupancy, 4'd0);
      chk("jmp_valid", cpu_valid, 1'b0);
      for (int i = 0; i < 60 && start_log.size() == 0; i++) tick();
      chk("jmp_addr", start_log.size() > 0 ? start_log[0] : 23'h7FFFFF, 23'h100);
      for (int i = 0; i < 60 && !cpu_valid; i++) tick();
      chk("jmp_data",    cpu_data,  exp_data(23'h100));
      chk("jmp_occ_one", occupancy, 4'd1);

      // Implicit miss with 0x20..0x2C buffered.
      cpu_req = 1'b0; cpu_flush = 1'b1; cpu_pc = 23'h20;
      tick();
      cpu_flush = 1'b0;
      for (int i = 0; i < 300 && occupancy != 4'd4; i++) tick();
      cpu_req = 1'b1;
      #1;
      chk("miss_head", cpu_valid, 1'b1);
      cpu_pc = 23'h40;
      #1;
      chk("miss_valid0", cpu_valid, 1'b0);
      start_log.delete();
      tick();
      chk("miss_occ", occupancy, 4'd0);
      for (int i = 0; i < 60 && !cpu_valid; i++) tick();
      chk("miss_addr", start_log.size() > 0 ? start_log[0] : 23'h7FFFFF, 23'h40);
      chk("miss_data", cpu_data, exp_data(23'h40));

      // Address wrap.
      cpu_req = 1'b0; cpu_flush = 1'b1; cpu_pc = 23'h7FFFF8;
      tick();
      cpu_flush = 1'b0;
      start_log.delete();
      for (int i = 0; i < 300 && occupancy != 4'd4; i++) tick();
      chk("wrap_n",  start_log.size(), 4);
      chk("wrap_a1", start_log.size() > 1 ? start_log[1] : 23'h1, 23'h7FFFFC);
      chk("wrap_a2", start_log.size() > 2 ? start_log[2] : 23'h1, 23'h000000);
      cpu_req = 1'b1; cpu_pc = 23'h7FFFF8; cpu_take = 1'b1;
      tick();
      cpu_pc = 23'h7FFFFC;
      tick();
      cpu_pc = 23'h0; cpu_take = 1'b0;
      #1;
      chk("wrap_valid", cpu_valid, 1'b1);
      chk("wrap_data",  cpu_data,  32'hA5A5A5A5);

      // Reset during a QSPI transaction.
      cpu_req = 1'b0;
      for (int i = 0; i < 50 && !qspi_busy; i++) tick();
      tick();
      rst = 1'b1; cpu_req = 1'b1; cpu_pc = 23'h0;
      tick();
      chk("mrst_occ",   occupancy,  4'd0);
      chk("mrst_valid", cpu_valid,  1'b0);
      chk("mrst_data",  cpu_data,   32'h0);
      chk("mrst_start", qspi_start, 1'b0);
      chk("mrst_addr",  qspi_addr,  23'h0);
      rst = 1'b0;
      start_log.delete();
      for (int i = 0; i < 60 && !cpu_valid; i++) tick();
      chk("mrst_fetch", start_log.size() > 0 ? start_log[0] : 23'h7FFFFF, 23'h0);
      chk("mrst_word",  cpu_data, 32'hA5A5A5A5);
      chk("no_start_busy", bad_start, 0);
      chk("occ_bound",     occ_over,  0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
